// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton engine.
// Holds the controller state encoding and the power-on defaults.
package eca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eca_state_e;

  localparam logic [7:0] RULE_110      = 8'd110;
  localparam int         GEN_W_DEFAULT = 16;

endpackage

// File: rtl/eca_rule_cell.sv
// One automaton cell: looks up its next state in the Wolfram rule table.
// The neighbourhood is ordered {left, centre, right}.
module eca_rule_cell (
  input  logic [2:0] nbhd,
  input  logic [7:0] rule,
  output logic       next_state
);

  assign next_state = rule[nbhd];

endmodule

// File: rtl/eca_engine.sv
// Elementary cellular automaton engine with block-wide host access.
// Runs a requested number of generations under a small IDLE/RUN/DONE controller.
module eca_engine
  import eca_pkg::*;
#(
  parameter int NUM_CELLS = 240,
  parameter int BLOCK_W   = 8,
  parameter int WRAP      = 1,
  parameter int GEN_W     = GEN_W_DEFAULT,
  localparam int NUM_BLOCKS = NUM_CELLS / BLOCK_W,
  localparam int ADDR_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rule,
  input  logic              rule_load,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic              start,
  input  logic [GEN_W-1:0]  n_gens,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  gen_count,
  output logic              wr_err
);

  eca_state_e          state_q, state_d;
  logic [NUM_CELLS-1:0] cells_q, cells_d;
  logic [NUM_CELLS-1:0] next_cells;
  logic [7:0]          rule_q, rule_d;
  logic [GEN_W-1:0]    remain_q, remain_d;
  logic [GEN_W-1:0]    gen_count_q, gen_count_d;
  logic [BLOCK_W-1:0]  rd_data_q, rd_data_d;
  logic                wr_err_q, wr_err_d;

  logic wrap_left, wrap_right;

  // Cell NUM_CELLS-1 is the left end; the edges either wrap or see a constant 0.
  assign wrap_left  = (WRAP != 0) ? cells_q[0]           : 1'b0;
  assign wrap_right = (WRAP != 0) ? cells_q[NUM_CELLS-1] : 1'b0;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    logic left_n, right_n;

    if (i == NUM_CELLS - 1) begin : g_left_edge
      assign left_n = wrap_left;
    end else begin : g_left_inner
      assign left_n = cells_q[i+1];
    end

    if (i == 0) begin : g_right_edge
      assign right_n = wrap_right;
    end else begin : g_right_inner
      assign right_n = cells_q[i-1];
    end

    eca_rule_cell u_rule_cell (
      .nbhd       ({left_n, cells_q[i], right_n}),
      .rule       (rule_q),
      .next_state (next_cells[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    rule_d      = rule_q;
    remain_d    = remain_q;
    gen_count_d = gen_count_q;
    wr_err_d    = 1'b0;
    rd_data_d   = '0;

    // Out-of-range read addresses match no block and so return 0.
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if ({1'b0, rd_addr} == (ADDR_W+1)'(b)) begin
        rd_data_d = cells_q[b*BLOCK_W +: BLOCK_W];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          for (int b = 0; b < NUM_BLOCKS; b++) begin
            if ({1'b0, wr_addr} == (ADDR_W+1)'(b)) begin
              cells_d[b*BLOCK_W +: BLOCK_W] = wr_data;
            end
          end
        end
        if (rule_load) begin
          rule_d = rule;
        end
        // A write in the same cycle wins; the start request is dropped and flagged.
        if (start) begin
          if (wr_en) begin
            wr_err_d = 1'b1;
          end else if (n_gens == '0) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            remain_d = n_gens;
          end
        end
      end

      RUN: begin
        wr_err_d = wr_en | rule_load | start;
        if (!halt) begin
          cells_d     = next_cells;
          remain_d    = remain_q - GEN_W'(1);
          gen_count_d = gen_count_q + GEN_W'(1);
          if (remain_q == GEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        wr_err_d = wr_en | rule_load | start;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cells_q     <= NUM_CELLS'(1);
      rule_q      <= RULE_110;
      remain_q    <= '0;
      gen_count_q <= '0;
      rd_data_q   <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      rule_q      <= rule_d;
      remain_q    <= remain_d;
      gen_count_q <= gen_count_d;
      rd_data_q   <= rd_data_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign gen_count = gen_count_q;
  assign rd_data   = rd_data_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_eca_engine.sv
// Directed bench for eca_engine: two 240-cell instances (wrapping and zero-padded)
// share stimulus, and a 16-cell zero-padded instance is driven separately.
module tb_eca_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rule;
  logic        rule_load;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  rd_addr;
  logic        start;
  logic [15:0] n_gens;
  logic        halt;

  logic [7:0]  rd_data_a, rd_data_b, rd_data_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [15:0] gen_count_a, gen_count_b, gen_count_c;
  logic        wr_err_a, wr_err_b, wr_err_c;

  logic        c_rule_load, c_wr_en, c_start;
  logic [0:0]  c_wr_addr, c_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;
  int done_pulses;
  logic [7:0] blk_a, blk_b;

  always #5 clk = ~clk;

  eca_engine #(.NUM_CELLS(240), .BLOCK_W(8), .WRAP(1), .GEN_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .rule(rule), .rule_load(rule_load),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a),
    .start(start), .n_gens(n_gens), .halt(halt),
    .busy(busy_a), .done(done_a), .gen_count(gen_count_a), .wr_err(wr_err_a)
  );

  eca_engine #(.NUM_CELLS(240), .BLOCK_W(8), .WRAP(0), .GEN_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .rule(rule), .rule_load(rule_load),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .start(start), .n_gens(n_gens), .halt(halt),
    .busy(busy_b), .done(done_b), .gen_count(gen_count_b), .wr_err(wr_err_b)
  );

  eca_engine #(.NUM_CELLS(16), .BLOCK_W(8), .WRAP(0), .GEN_W(16)) u_dut_c (
    .clk(clk), .reset(reset), .rule(rule), .rule_load(c_rule_load),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(wr_data),
    .rd_addr(c_rd_addr), .rd_data(rd_data_c),
    .start(c_start), .n_gens(n_gens), .halt(halt),
    .busy(busy_c), .done(done_c), .gen_count(gen_count_c), .wr_err(wr_err_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [15:0] gens);
    start  = 1'b1;
    n_gens = gens;
    tick();
    start  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic read_block_ab(input logic [4:0] addr, output logic [7:0] a,
                               output logic [7:0] b);
    rd_addr = addr;
    tick();
    a = rd_data_a;
    b = rd_data_b;
  endtask

  task automatic wait_done(input bit use_c, input int limit, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if ((use_c ? done_c : done_a) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; rule = 8'd0; rule_load = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rd_addr = '0; start = 1'b0; n_gens = '0; halt = 1'b0;
    c_rule_load = 1'b0; c_wr_en = 1'b0; c_start = 1'b0; c_wr_addr = '0; c_rd_addr = '0;

    $display("[TB] reset state");
    do_reset();
    checkOutput("reset busy", {31'd0, busy_a}, 32'd0);
    checkOutput("reset done", {31'd0, done_a}, 32'd0);
    checkOutput("reset wr_err", {31'd0, wr_err_a}, 32'd0);
    checkOutput("reset gen_count", {16'd0, gen_count_a}, 32'd0);
    checkOutput("reset rd_data", {24'd0, rd_data_a}, 32'd0);
    read_block_ab(5'd0, blk_a, blk_b);
    checkOutput("reset block0", {24'd0, blk_a}, 32'h01);

    // Rule 110 from a lone cell 0 grows toward the left end only, so cell 239 stays 0.
    $display("[TB] rule 110, one generation");
    applyStimulus(16'd1);
    checkOutput("run1 busy", {31'd0, busy_a}, 32'd1);
    checkOutput("run1 done early", {31'd0, done_a}, 32'd0);
    tick();
    checkOutput("run1 done", {31'd0, done_a}, 32'd1);
    checkOutput("run1 busy after", {31'd0, busy_a}, 32'd0);
    checkOutput("run1 gen_count", {16'd0, gen_count_a}, 32'd1);
    tick();
    checkOutput("run1 done cleared", {31'd0, done_a}, 32'd0);
    read_block_ab(5'd0, blk_a, blk_b);
    checkOutput("run1 wrap block0", {24'd0, blk_a}, 32'h03);
    checkOutput("run1 pad block0", {24'd0, blk_b}, 32'h03);
    read_block_ab(5'd29, blk_a, blk_b);
    checkOutput("run1 wrap block29", {24'd0, blk_a}, 32'h00);

    $display("[TB] wrap versus padding");
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h00;
    tick();
    wr_addr = 5'd29; wr_data = 8'h80;
    tick();
    wr_en = 1'b0;
    checkOutput("idle write wr_err", {31'd0, wr_err_a}, 32'd0);
    applyStimulus(16'd1);
    wait_done(1'b0, 5, "edge run done");
    read_block_ab(5'd0, blk_a, blk_b);
    checkOutput("edge wrap block0", {24'd0, blk_a}, 32'h01);
    checkOutput("edge pad block0", {24'd0, blk_b}, 32'h00);
    read_block_ab(5'd29, blk_a, blk_b);
    checkOutput("edge wrap block29", {24'd0, blk_a}, 32'h80);
    checkOutput("edge pad block29", {24'd0, blk_b}, 32'h80);

    $display("[TB] out-of-range block access");
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    checkOutput("oor write wr_err", {31'd0, wr_err_a}, 32'd0);
    read_block_ab(5'd30, blk_a, blk_b);
    checkOutput("oor read", {24'd0, blk_a}, 32'h00);

    $display("[TB] halted run");
    do_reset();
    busy_cycles = 0;
    done_pulses = 0;
    applyStimulus(16'd5);
    for (int k = 0; k < 20; k++) begin
      if (busy_a === 1'b1) busy_cycles++;
      if (done_a === 1'b1) done_pulses++;
      halt = (k >= 2 && k <= 4);
      tick();
    end
    halt = 1'b0;
    checkOutput("halt busy cycles", busy_cycles, 32'd8);
    checkOutput("halt done pulses", done_pulses, 32'd1);
    checkOutput("halt gen_count", {16'd0, gen_count_a}, 32'd5);

    $display("[TB] rejected accesses during a run");
    do_reset();
    rule = 8'd204; rule_load = 1'b1;
    tick();
    rule_load = 1'b0;
    applyStimulus(16'd6);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    checkOutput("run write wr_err", {31'd0, wr_err_a}, 32'd1);
    tick();
    checkOutput("run write wr_err clear", {31'd0, wr_err_a}, 32'd0);
    rule = 8'd0; rule_load = 1'b1;
    tick();
    rule_load = 1'b0;
    checkOutput("run rule_load wr_err", {31'd0, wr_err_a}, 32'd1);
    tick();
    checkOutput("run rule_load wr_err clear", {31'd0, wr_err_a}, 32'd0);
    start = 1'b1; n_gens = 16'd2;
    tick();
    start = 1'b0;
    checkOutput("run start wr_err", {31'd0, wr_err_a}, 32'd1);
    tick();
    checkOutput("run6 done", {31'd0, done_a}, 32'd1);
    checkOutput("run6 gen_count", {16'd0, gen_count_a}, 32'd6);
    tick();
    read_block_ab(5'd0, blk_a, blk_b);
    checkOutput("run6 block0 kept", {24'd0, blk_a}, 32'h01);
    applyStimulus(16'd1);
    wait_done(1'b0, 5, "rule kept run done");
    read_block_ab(5'd0, blk_a, blk_b);
    checkOutput("rule kept block0", {24'd0, blk_a}, 32'h01);

    $display("[TB] write beats start in idle");
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h0F; start = 1'b1; n_gens = 16'd3;
    tick();
    wr_en = 1'b0; start = 1'b0;
    checkOutput("write+start busy", {31'd0, busy_a}, 32'd0);
    checkOutput("write+start wr_err", {31'd0, wr_err_a}, 32'd1);
    read_block_ab(5'd1, blk_a, blk_b);
    checkOutput("write+start block1", {24'd0, blk_a}, 32'h0F);

    $display("[TB] zero-generation run and reset mid-run");
    applyStimulus(16'd0);
    checkOutput("zero done", {31'd0, done_a}, 32'd1);
    checkOutput("zero busy", {31'd0, busy_a}, 32'd0);
    checkOutput("zero gen_count", {16'd0, gen_count_a}, 32'd7);
    tick();
    checkOutput("zero done cleared", {31'd0, done_a}, 32'd0);
    read_block_ab(5'd1, blk_a, blk_b);
    checkOutput("zero block1", {24'd0, blk_a}, 32'h0F);
    applyStimulus(16'd100);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("long run busy", {31'd0, busy_a}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("midrun reset busy", {31'd0, busy_a}, 32'd0);
    checkOutput("midrun reset done", {31'd0, done_a}, 32'd0);
    checkOutput("midrun reset gen_count", {16'd0, gen_count_a}, 32'd0);
    checkOutput("midrun reset rd_data", {24'd0, rd_data_a}, 32'd0);
    reset = 1'b0;
    done_pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done_a === 1'b1) done_pulses++;
    end
    checkOutput("midrun reset no done", done_pulses, 32'd0);
    read_block_ab(5'd0, blk_a, blk_b);
    checkOutput("midrun reset block0", {24'd0, blk_a}, 32'h01);

    // Rule 90 from cell 4 after three generations gives cells 1,3,5,7.
    $display("[TB] rule 90 on 16 cells");
    rule = 8'd90; c_rule_load = 1'b1; c_wr_en = 1'b1; c_wr_addr = 1'b0; wr_data = 8'h10;
    tick();
    c_rule_load = 1'b0; c_wr_en = 1'b0;
    c_start = 1'b1; n_gens = 16'd3;
    tick();
    c_start = 1'b0;
    wait_done(1'b1, 10, "rule90 done");
    checkOutput("rule90 gen_count", {16'd0, gen_count_c}, 32'd3);
    tick();
    c_rd_addr = 1'b0;
    tick();
    checkOutput("rule90 block0", {24'd0, rd_data_c}, 32'hAA);
    c_rd_addr = 1'b1;
    tick();
    checkOutput("rule90 block1", {24'd0, rd_data_c}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
